// File: rtl/spi_shift_engine_pkg.sv
// Shared definitions for the SPI shift engine: FSM encoding, SPI mode codes
// and the counter-width helper.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Mode code is {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int cnt_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/spi_shift_engine_if.sv
// Bundle of FIFO handshake, mode control and SPI pin signals around the shift engine.
// The master modport is the engine's view; slave is the surrounding system's view.
interface spi_shift_engine_if #(
  parameter int WIDTH = 8
) ();
  logic             en;
  logic             cpol;
  logic             cpha;
  logic             tx_empty;
  logic             tx_re;
  logic [WIDTH-1:0] tx_data;
  logic             rx_full;
  logic             rx_we;
  logic [WIDTH-1:0] rx_data;
  logic             sclk;
  logic             mosi;
  logic             miso;
  logic             cs_n;
  logic             busy;

  modport master (
    input  en, cpol, cpha, tx_empty, tx_data, rx_full, miso,
    output tx_re, rx_we, rx_data, sclk, mosi, cs_n, busy
  );

  modport slave (
    output en, cpol, cpha, tx_empty, tx_data, rx_full, miso,
    input  tx_re, rx_we, rx_data, sclk, mosi, cs_n, busy
  );
endinterface

// File: rtl/spi_shift_engine_clk_gen.sv
// SCLK half-period timer: emits a one-cycle tick at each half-period end and
// flags whether that tick is a leading (odd-numbered) edge.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic clear_i,
  output logic tick_o,
  output logic lead_o
);

  localparam int CW = cnt_width(CLK_DIV);
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  assign tick_o = run_i & ~clear_i & (cnt_q == TERM);
  assign lead_o = ~phase_q;

  // Next counter/phase value
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clear_i) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (run_i) begin
      if (cnt_q == TERM) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d   = cnt_q + CW'(1);
      end
    end else begin
      cnt_d   = cnt_q;
    end
  end

  // Counter and phase registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/spi_shift_engine.sv
// SPI shift engine: pops TX FIFO words, shifts them out MSB-first on MOSI while
// sampling MISO, and pushes each received word into the RX FIFO (all four modes).
module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  spi_shift_engine_if.master bus
);

  localparam int EW = cnt_width(2 * WIDTH);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic [EW-1:0]    edge_q, edge_d;
  logic [1:0]       mode_q, mode_d;
  logic             last_q, last_d;
  logic             rx_bit_q, rx_bit_d;
  logic             tx_re_q, tx_re_d;
  logic             rx_we_q, rx_we_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             cs_n_q, cs_n_d;
  logic             busy_q, busy_d;
  logic             start_s, tick_s, lead_s, run_s, clear_s;
  logic             cpol_s, cpha_s;

  assign start_s = bus.en & ~bus.tx_empty & ~bus.rx_full;
  assign run_s   = (state_q == ST_SHIFT);
  assign clear_s = (state_q == ST_LOAD);
  assign cpol_s  = (mode_q == MODE2) | (mode_q == MODE3);
  assign cpha_s  = (mode_q == MODE1) | (mode_q == MODE3);

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk     (clk),
    .rst     (rst),
    .run_i   (run_s),
    .clear_i (clear_s),
    .tick_o  (tick_s),
    .lead_o  (lead_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; last_q marks the extra half-period after the final edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = start_s ? ST_FETCH : ST_IDLE;
      ST_FETCH: state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: state_d = (tick_s && last_q) ? ST_DONE : ST_SHIFT;
      ST_DONE:  state_d = start_s ? ST_FETCH : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    tx_re_d   = 1'b0;
    rx_we_d   = 1'b0;
    rx_data_d = rx_data_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    busy_d    = (state_d != ST_IDLE);
    shift_d   = shift_q;
    rx_bit_d  = rx_bit_q;
    edge_d    = edge_q;
    last_d    = last_q;
    mode_d    = mode_q;
    case (state_q)
      ST_IDLE: begin
        sclk_d = bus.cpol;
        cs_n_d = 1'b1;
        if (start_s) begin
          tx_re_d = 1'b1;
          mode_d  = {bus.cpol, bus.cpha};
        end else begin
          tx_re_d = 1'b0;
        end
      end
      ST_FETCH: begin
        tx_re_d = 1'b0;
      end
      ST_LOAD: begin
        shift_d = bus.tx_data;
        cs_n_d  = 1'b0;
        sclk_d  = cpol_s;
        edge_d  = '0;
        last_d  = 1'b0;
        if (!cpha_s) begin
          mosi_d = bus.tx_data[WIDTH-1];
        end else begin
          mosi_d = mosi_q;
        end
      end
      ST_SHIFT: begin
        if (tick_s && !last_q) begin
          sclk_d = ~sclk_q;
          if (edge_q == LAST_EDGE) begin
            edge_d = '0;
            last_d = 1'b1;
          end else begin
            edge_d = edge_q + EW'(1);
          end
          // Sampling edge is leading for cpha=0, trailing for cpha=1
          if (lead_s != cpha_s) begin
            if (cpha_s) begin
              shift_d = {shift_q[WIDTH-1:1], bus.miso};
            end else begin
              rx_bit_d = bus.miso;
            end
          end else begin
            if (cpha_s) begin
              mosi_d  = shift_q[WIDTH-1];
              shift_d = {shift_q[WIDTH-2:0], 1'b0};
            end else begin
              mosi_d  = shift_q[WIDTH-2];
              shift_d = {shift_q[WIDTH-2:0], rx_bit_q};
            end
          end
        end else begin
          sclk_d = sclk_q;
        end
      end
      ST_DONE: begin
        rx_we_d   = 1'b1;
        rx_data_d = shift_q;
        if (start_s) begin
          tx_re_d = 1'b1;
        end else begin
          cs_n_d = 1'b1;
          mosi_d = 1'b0;
        end
      end
      default: begin
        cs_n_d = 1'b1;
      end
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_re_q   <= 1'b0;
      rx_we_q   <= 1'b0;
      rx_data_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      shift_q   <= '0;
      rx_bit_q  <= 1'b0;
      edge_q    <= '0;
      last_q    <= 1'b0;
      mode_q    <= MODE0;
    end else begin
      tx_re_q   <= tx_re_d;
      rx_we_q   <= rx_we_d;
      rx_data_q <= rx_data_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      shift_q   <= shift_d;
      rx_bit_q  <= rx_bit_d;
      edge_q    <= edge_d;
      last_q    <= last_d;
      mode_q    <= mode_d;
    end
  end

  assign bus.tx_re   = tx_re_q;
  assign bus.rx_we   = rx_we_q;
  assign bus.rx_data = rx_data_q;
  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.cs_n    = cs_n_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine: TX FIFO model, pin monitor and
// directed plus randomized frames checked against the SPI frame rules.
module tb_spi_shift_engine;

  localparam int W   = 8;
  localparam int D   = 2;
  localparam int LAT = 2 + 2 * W * D + D + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_shift_engine_if #(.WIDTH(W)) bus ();
  spi_shift_engine #(.WIDTH(W), .CLK_DIV(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_assert = 0;
  int n_fail   = 0;

  logic loopback;
  logic miso_val;
  assign bus.miso = loopback ? bus.mosi : miso_val;

  // TX FIFO model: registered dout, popped by tx_re
  logic [7:0] tx_mem [0:255];
  int tx_wr = 0;
  int tx_rd = 0;
  assign bus.tx_empty = (tx_rd == tx_wr);
  always @(posedge clk) begin
    if (bus.tx_re === 1'b1 && tx_rd != tx_wr) begin
      bus.tx_data <= tx_mem[tx_rd % 256];
      tx_rd       <= tx_rd + 1;
    end
  end

  // Pin monitor, sampled on the falling clock edge
  int         cyc = 0;
  logic [7:0] rx_q[$];
  int         rx_cyc[$];
  int         tx_cyc[$];
  int         edge_cyc[$];
  logic       edge_mosi[$];
  logic       edge_csn[$];
  int         cs_rise = 0;
  int         bad_re  = 0;
  logic       sclk_prev = 1'b0;
  logic       csn_prev  = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.tx_re === 1'b1) begin
      tx_cyc.push_back(cyc);
      if (bus.tx_empty) bad_re <= bad_re + 1;
    end
    if (bus.rx_we === 1'b1) begin
      rx_q.push_back(bus.rx_data);
      rx_cyc.push_back(cyc);
    end
    if (bus.sclk !== sclk_prev) begin
      edge_cyc.push_back(cyc);
      edge_mosi.push_back(bus.mosi);
      edge_csn.push_back(bus.cs_n);
    end
    if (bus.cs_n === 1'b1 && csn_prev === 1'b0) cs_rise <= cs_rise + 1;
    sclk_prev <= bus.sclk;
    csn_prev  <= bus.cs_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input logic [7:0] w);
    tx_mem[tx_wr % 256] = w;
    tx_wr++;
  endtask

  task automatic wait_rx(input int target, input string tag);
    int i;
    i = 0;
    while (rx_q.size() < target && i < 400) begin
      step(1);
      i++;
    end
    check(tag, rx_q.size() >= target, 1);
  endtask

  task automatic wait_edges(input int target, input string tag);
    int i;
    i = 0;
    while (edge_cyc.size() < target && i < 400) begin
      step(1);
      i++;
    end
    check(tag, edge_cyc.size() >= target, 1);
  endtask

  // A frame: MSB-first bits on MOSI at the sampling edges, SCLK edges every D cycles
  // with CS_N low, received word, and tx_re-to-rx_we latency.
  task automatic check_frame(input string tag, input logic [7:0] word, input logic [7:0] exp_rx,
                             input logic cpha_m, input int e0, input int r0, input int t0);
    logic [7:0] bits;
    bit         gap_ok, csn_ok;
    int         k;
    bits   = 8'h00;
    gap_ok = 1'b1;
    csn_ok = 1'b1;
    if (edge_cyc.size() < e0 + 2 * W) begin
      gap_ok = 1'b0;
    end else begin
      for (int i = 0; i < 2 * W; i++) begin
        if (i > 0 && edge_cyc[e0 + i] - edge_cyc[e0 + i - 1] != D) gap_ok = 1'b0;
        if (edge_csn[e0 + i] !== 1'b0) csn_ok = 1'b0;
      end
    end
    for (int b = 0; b < W; b++) begin
      k = e0 + 2 * b + (cpha_m ? 1 : 0);
      bits[W - 1 - b] = (k < edge_mosi.size()) ? edge_mosi[k] : 1'bx;
    end
    check({tag, "_mosi"}, bits, word);
    check({tag, "_gap"}, gap_ok, 1);
    check({tag, "_csn"}, csn_ok, 1);
    check({tag, "_present"}, (rx_q.size() > r0) && (tx_cyc.size() > t0), 1);
    if (rx_q.size() > r0 && tx_cyc.size() > t0) begin
      check({tag, "_rx"}, rx_q[r0], exp_rx);
      check({tag, "_lat"}, rx_cyc[r0] - tx_cyc[t0], LAT);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0, r0, t0, c0;
    logic [7:0] w, wa, wb, exp_rx;
    logic cp, ch;

    rst = 1'b1; bus.en = 1'b0; bus.cpol = 1'b0; bus.cpha = 1'b0; bus.rx_full = 1'b0;
    loopback = 1'b1; miso_val = 1'b0;
    #1 rst = 1'b0;
    step(2);
    check("rst_tx_re", bus.tx_re, 0);
    check("rst_rx_we", bus.rx_we, 0);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_sclk", bus.sclk, 0);
    check("rst_mosi", bus.mosi, 0);
    check("rst_cs_n", bus.cs_n, 1);
    check("rst_busy", bus.busy, 0);
    rst = 1'b1;
    step(2);

    // Mode 0, loopback, 0xA5
    e0 = edge_cyc.size(); r0 = rx_q.size(); t0 = tx_cyc.size();
    push(8'hA5);
    bus.en = 1'b1;
    wait_rx(r0 + 1, "m0_wait");
    check("m0_tx_re_cnt", tx_cyc.size() - t0, 1);
    check("m0_edges", edge_cyc.size() - e0, 2 * W);
    check_frame("m0", 8'hA5, 8'hA5, 1'b0, e0, r0, t0);
    check("m0_cs_n_end", bus.cs_n, 1);
    step(3);
    check("m0_busy_end", bus.busy, 0);

    // Mode 3, miso tied high, 0x3C
    bus.en = 1'b0; bus.cpol = 1'b1; bus.cpha = 1'b1; loopback = 1'b0; miso_val = 1'b1;
    step(2);
    check("m3_sclk_idle", bus.sclk, 1);
    e0 = edge_cyc.size(); r0 = rx_q.size(); t0 = tx_cyc.size();
    push(8'h3C);
    bus.en = 1'b1;
    wait_rx(r0 + 1, "m3_wait");
    check_frame("m3", 8'h3C, 8'hFF, 1'b1, e0, r0, t0);
    step(2);
    check("m3_sclk_after", bus.sclk, 1);

    // Back-to-back burst, mode 0 loopback
    bus.en = 1'b0; bus.cpol = 1'b0; bus.cpha = 1'b0; loopback = 1'b1;
    step(2);
    e0 = edge_cyc.size(); r0 = rx_q.size(); t0 = tx_cyc.size(); c0 = cs_rise;
    push(8'h12); push(8'h34);
    bus.en = 1'b1;
    wait_rx(r0 + 2, "b2b_wait");
    check("b2b_edges", edge_cyc.size() - e0, 4 * W);
    check_frame("b2b0", 8'h12, 8'h12, 1'b0, e0, r0, t0);
    check_frame("b2b1", 8'h34, 8'h34, 1'b0, e0 + 2 * W, r0 + 1, t0 + 1);
    check("b2b_cs_rise", cs_rise - c0, 1);
    step(3);
    check("b2b_idle", bus.busy, 0);

    // Flow control on rx_full
    bus.rx_full = 1'b1;
    r0 = rx_q.size(); t0 = tx_cyc.size();
    push(8'h5A);
    step(10);
    check("fc_no_tx_re", tx_cyc.size() - t0, 0);
    check("fc_cs_n", bus.cs_n, 1);
    bus.rx_full = 1'b0;
    step(1);
    check("fc_start", bus.tx_re, 1);
    wait_rx(r0 + 1, "fc_wait");
    check("fc_rx", rx_q[r0], 8'h5A);

    // Reset in the middle of SHIFT
    bus.en = 1'b0;
    step(3);
    wa = 8'hC3; wb = 8'h96;
    e0 = edge_cyc.size(); r0 = rx_q.size();
    push(wa); push(wb);
    bus.en = 1'b1;
    wait_edges(e0 + 5, "rst_wait_edges");
    rst = 1'b0;
    #1;
    check("rst_mid_cs_n", bus.cs_n, 1);
    check("rst_mid_sclk", bus.sclk, 0);
    step(1);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_rx_we", bus.rx_we, 0);
    step(2);
    check("rst_mid_no_rx", rx_q.size() - r0, 0);
    e0 = edge_cyc.size(); t0 = tx_cyc.size();
    rst = 1'b1;
    wait_rx(r0 + 1, "rst_fresh_wait");
    check_frame("rst_fresh", wb, wb, 1'b0, e0, r0, t0);

    // Mode and enable changes during a frame
    bus.en = 1'b0;
    step(3);
    wa = 8'h6B; wb = 8'hE1;
    e0 = edge_cyc.size(); r0 = rx_q.size(); t0 = tx_cyc.size();
    push(wa); push(wb);
    bus.en = 1'b1;
    wait_edges(e0 + 3, "mid_wait_edges");
    bus.cpha = 1'b1; bus.en = 1'b0;
    wait_rx(r0 + 1, "mid_wait");
    check_frame("mid", wa, wa, 1'b0, e0, r0, t0);
    step(40);
    check("mid_tx_re_cnt", tx_cyc.size() - t0, 1);
    check("mid_rx_cnt", rx_q.size() - r0, 1);
    check("mid_fifo_left", tx_wr - tx_rd, 1);
    check("mid_busy", bus.busy, 0);
    bus.cpha = 1'b0;
    r0 = rx_q.size();
    bus.en = 1'b1;
    wait_rx(r0 + 1, "drain_wait");
    check("drain_rx", rx_q[r0], wb);

    // Randomized frames against the frame rules
    for (int n = 0; n < 6; n++) begin
      bus.en = 1'b0;
      cp = 1'($urandom_range(1, 0));
      ch = 1'($urandom_range(1, 0));
      w  = 8'($urandom);
      loopback = 1'($urandom_range(1, 0));
      miso_val = 1'($urandom_range(1, 0));
      bus.cpol = cp; bus.cpha = ch;
      step(3);
      check("rnd_sclk_idle", bus.sclk, cp);
      e0 = edge_cyc.size(); r0 = rx_q.size(); t0 = tx_cyc.size();
      push(w);
      bus.en = 1'b1;
      wait_rx(r0 + 1, "rnd_wait");
      exp_rx = loopback ? w : {8{miso_val}};
      check_frame("rnd", w, exp_rx, ch, e0, r0, t0);
      step(3);
      check("rnd_cs_n_end", bus.cs_n, 1);
    end

    bus.en = 1'b0;
    step(2);
    check("no_tx_re_when_empty", bad_re, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
Serial shift engine of the spi_master core. Sits between the TX FIFO and the RX FIFO, both instances of the team's spi_fifo. Pops a word from the TX FIFO, shifts it out MSB-first on MOSI while sampling MISO, then pushes the received word into the RX FIFO. Generates SCLK and CS_N for all four SPI modes (CPOL/CPHA).

Parameters:
WIDTH, 8, frame/word width in bits; must match the FIFO WIDTH.
CLK_DIV, 4, SCLK half-period in clk cycles; must be >= 1.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
en  in  1  enable; when low, no new frame starts
cpol  in  1  SCLK idle level
cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge
tx_empty  in  1  TX FIFO empty
tx_re  out  1  TX FIFO read strobe, 1-cycle pulse
tx_data  in  WIDTH  TX FIFO dout, valid the cycle after tx_re
rx_full  in  1  RX FIFO full
rx_we  out  1  RX FIFO write strobe, 1-cycle pulse
rx_data  out  WIDTH  received word, valid while rx_we=1 and held afterwards
sclk  out  1  SPI clock
mosi  out  1  SPI data out
miso  in  1  SPI data in (treated as synchronous to clk)
cs_n  out  1  chip select, active low
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values: tx_re=0, rx_we=0, rx_data=0, sclk=0, mosi=0, cs_n=1, busy=0, FSM=IDLE, all counters 0. Reset mid-frame aborts immediately; no partial rx_we.
- All outputs are registered.
- FSM states: IDLE, FETCH, LOAD, SHIFT, DONE.
- IDLE:
  - sclk follows cpol; cs_n=1.
  - If en && !tx_empty && !rx_full: pulse tx_re, latch cpol/cpha into mode registers, go to FETCH.
- FETCH: wait one cycle for the FIFO's registered dout; go to LOAD.
- LOAD:
  - Capture tx_data into the shift register; cs_n<=0.
  - If the latched cpha=0, mosi<=MSB.
  - Clear the half-period counter and edge counter; go to SHIFT.
- SHIFT:
  - Half-period counter counts 0..CLK_DIV-1. At terminal count, toggle sclk and increment the edge counter (0..2*WIDTH-1).
  - Odd edge numbers (1st, 3rd, ...) are leading edges.
  - cpha=0: sample miso into shift LSB on leading edges; shift and drive the next MSB on trailing edges.
  - cpha=1: drive MSB/shift on leading edges; sample on trailing edges.
  - After the 2*WIDTH-th edge, sclk is back at cpol. Wait one further half-period, then go to DONE.
- DONE:
  - Pulse rx_we with rx_data = received word.
  - If en && !tx_empty && !rx_full: pulse tx_re and go to FETCH, with cs_n held low (continuous burst).
  - Otherwise cs_n<=1, mosi<=0, go to IDLE.
- Frame latency: tx_re to rx_we = 2 + 2*WIDTH*CLK_DIV + CLK_DIV + 1 cycles.
- cpol/cpha changes mid-frame are ignored; the latched values are used until IDLE.
- en deasserted mid-frame: the current frame completes; no new frame starts.
- tx_re is never asserted when tx_empty=1. rx_we never overflows, because a frame only starts when rx_full=0 and this block is the RX FIFO's sole writer.
- MISO is sampled in the same clk cycle as the sampling SCLK edge is issued.

Decomposition:
- Shared package spi_pkg:
  - FSM state encoding (localparam/enum for IDLE..DONE).
  - SPI mode constants MODE0..MODE3.
  - Helper function for counter width: $clog2 of CLK_DIV and of 2*WIDTH.
- One sub-module, spi_clk_gen:
  - Half-period counter.
  - Outputs a 1-cycle tick plus a leading/trailing flag.
  - Controlled by run/clear inputs.

Test Plan:
- Mode 0, CLK_DIV=2, WIDTH=8, miso looped to mosi, TX FIFO holds 0xA5 -> one tx_re pulse, 16 sclk edges with period 4 clk, mosi bit sequence 1,0,1,0,0,1,0,1, rx_we pulse with rx_data=0xA5, cs_n returns high.
- Mode 3 (cpol=1, cpha=1), miso tied 1, TX word 0x3C -> sclk idles high, rx_data=0xFF, latency 2+32+2+1 = 37 cycles from tx_re to rx_we.
- Back-to-back: TX FIFO holds 0x12, 0x34 -> cs_n stays low across both frames, two rx_we pulses carrying 0x12 and 0x34 (loopback), then IDLE.
- Flow control: rx_full=1 with tx_empty=0 -> tx_re stays 0, cs_n stays 1. Release rx_full -> frame starts next cycle.
- Reset mid-SHIFT (after 5 edges) -> next cycle cs_n=1, sclk=0, busy=0, no rx_we. After reset release, a fresh frame sends the full next word.
- Change cpha 0->1 mid-frame, and deassert en mid-frame -> the current frame completes in the original mode, and no further tx_re is issued.
